// File: rtl/divisor_pkg.sv
// divisor_pkg: shared types and constants for the divider job scheduler.
//   W_DEF / TAG_W_DEF : default operand and tag widths
//   ERR_*             : result error codes carried on out_err
//   state_t           : scheduler FSM states
//   job_t             : one queued division job at the default widths
package divisor_pkg;

  localparam int W_DEF     = 16;
  localparam int TAG_W_DEF = 4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, EMIT} state_t;

  typedef struct packed {
    logic signed [W_DEF-1:0] num;
    logic signed [W_DEF-1:0] den;
    logic [TAG_W_DEF-1:0]    tag;
  } job_t;

endpackage

// File: rtl/divisor_job_fifo.sv
// divisor_job_fifo: synchronous FIFO holding packed division jobs.
//   CLK, RSTa     : clock, async active-low reset (empties the FIFO)
//   push, wdata   : write request (ignored while full)
//   pop, rdata    : read request (ignored while empty); rdata shows the head
//   full, empty   : occupancy flags
module divisor_job_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RSTa,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // never frees a slot for a simultaneous push.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/divisor_job_scheduler.sv
// divisor_job_scheduler: queues signed division jobs, feeds them one at a
// time to an external divider over a Start/Done level handshake, and
// returns quotient/remainder with tag and error code.
//   in_*     : job stream (valid/ready), in_ready = !fifo_full
//   out_*    : result stream (valid/ready), fields held until accepted
//   div_*    : divider handshake; div_start high for the whole ISSUE state
//   out_err  : 00 ok, 01 divide-by-zero (trapped here), 10 divider timeout
module divisor_job_scheduler
  import divisor_pkg::*;
#(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_num,
  input  logic [W-1:0]     in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_coc,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_err,
  output logic             div_start,
  output logic [W-1:0]     div_num,
  output logic [W-1:0]     div_den,
  input  logic             div_done,
  input  logic [W-1:0]     div_coc,
  input  logic [W-1:0]     div_res
);

  localparam int JW = 2 * W + TAG_W;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Same layout as job_t, sized by this instance's parameters.
  typedef struct packed {
    logic [W-1:0]     num;
    logic [W-1:0]     den;
    logic [TAG_W-1:0] tag;
  } jobw_t;

  jobw_t          in_job, head;
  logic [JW-1:0]  head_raw;
  logic           fifo_full, fifo_empty, pop;
  state_t         state, nxt;
  logic [TW-1:0]  tcnt;
  logic           tmo;
  logic [W-1:0]   coc_q, res_q, num_q, den_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]     err_q;

  assign in_job   = '{num: in_num, den: in_den, tag: in_tag};
  assign head     = jobw_t'(head_raw);
  assign in_ready = !fifo_full;

  divisor_job_fifo #(.DW(JW), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .push  (in_valid),
    .wdata (JW'(in_job)),
    .pop   (pop),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    pop = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) begin
        pop = 1'b1;
        nxt = (head.den == '0) ? EMIT : ISSUE;
      end
      ISSUE:   if (div_done || tmo) nxt = RELEASE;
      // Wait for Done to fall so a stale Done cannot finish the next job.
      RELEASE: if (!div_done) nxt = EMIT;
      EMIT:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      tcnt  <= '0;
      coc_q <= '0;
      res_q <= '0;
      tag_q <= '0;
      err_q <= ERR_OK;
      num_q <= '0;
      den_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (!fifo_empty) begin
          tag_q <= head.tag;
          tcnt  <= '0;
          if (head.den == '0) begin
            // Trapped locally; the divider operands are left untouched.
            coc_q <= '0;
            res_q <= head.num;
            err_q <= ERR_DIV0;
          end else begin
            num_q <= head.num;
            den_q <= head.den;
          end
        end
        ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (div_done) begin
            coc_q <= div_coc;
            res_q <= div_res;
            err_q <= ERR_OK;
          end else if (tmo) begin
            coc_q <= '0;
            res_q <= '0;
            err_q <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign div_start = (state == ISSUE);
  assign out_valid = (state == EMIT);
  assign div_num   = num_q;
  assign div_den   = den_q;
  assign out_coc   = coc_q;
  assign out_res   = res_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_divisor_job_scheduler.sv
module tb_divisor_job_scheduler;

  logic        CLK = 1'b0;
  logic        RSTa = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_num = '0, in_den = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_coc, out_res;
  logic [3:0]  out_tag;
  logic [1:0]  out_err;
  logic        div_start, div_done;
  logic [15:0] div_num, div_den, div_coc, div_res;

  int n_chk = 0, n_pass = 0;

  divisor_job_scheduler #(.W(16), .DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coc(out_coc), .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_coc(div_coc), .div_res(div_res)
  );

  always #5 CLK = ~CLK;

  // Divider stand-in: Done rises a few cycles after Start, holds until Start drops.
  logic dmodel_en = 1'b1;
  int   dcnt;
  logic signed [15:0] sn, sd;
  assign sn = div_num;
  assign sd = div_den;

  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      div_done <= 1'b0; dcnt <= 0; div_coc <= '0; div_res <= '0;
    end else if (!div_start) begin
      div_done <= 1'b0; dcnt <= 0;
    end else if (dmodel_en && !div_done) begin
      if (dcnt == 3) begin
        div_done <= 1'b1;
        div_coc  <= sn / sd;
        div_res  <= sn % sd;
      end else dcnt <= dcnt + 1;
    end
  end

  // Start activity monitor
  logic start_q = 1'b0;
  int   rises = 0, hi_cyc = 0;
  always @(posedge CLK) begin
    start_q <= div_start;
    if (div_start && !start_q) rises <= rises + 1;
    if (div_start) hi_cyc <= hi_cyc + 1;
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic push(input logic [15:0] n, input logic [15:0] d, input logic [3:0] tg);
    int t = 0;
    in_num = n; in_den = d; in_tag = tg; in_valid = 1'b1;
    while (!in_ready && t < 300) begin @(negedge CLK); t++; end
    if (!in_ready) chk("push_wait", 16'(in_ready), 16'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic get_res(input string nm, input logic [15:0] ec, input logic [15:0] er,
                         input logic [3:0] et, input logic [1:0] ee);
    int t = 0;
    while (!out_valid && t < 300) begin @(negedge CLK); t++; end
    chk({nm, "_valid"}, 16'(out_valid), 16'd1);
    chk({nm, "_coc"},   out_coc, ec);
    chk({nm, "_res"},   out_res, er);
    chk({nm, "_tag"},   16'(out_tag), 16'(et));
    chk({nm, "_err"},   16'(out_err), 16'(ee));
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, h0, t;
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_div_start", 16'(div_start), 16'd0);
    chk("rst_out_coc",   out_coc, 16'd0);
    chk("rst_div_num",   div_num, 16'd0);
    RSTa = 1'b1;
    @(negedge CLK);

    // Single job, latency to Start
    r0 = rises;
    push(16'd17, 16'd3, 4'd1);
    chk("lat_c1_start", 16'(div_start), 16'd0);
    @(negedge CLK);
    chk("lat_c2_start", 16'(div_start), 16'd1);
    get_res("j1", 16'd5, 16'd2, 4'd1, 2'b00);
    chk("j1_rises", 16'(rises - r0), 16'd1);

    // Back-to-back, mixed signs
    r0 = rises;
    push(-16'sd23, -16'sd5, 4'd2);
    push(16'd17,   -16'sd3, 4'd3);
    push(-16'sd18, 16'd3,   4'd4);
    get_res("b2", 16'd4,    -16'sd3, 4'd2, 2'b00);
    get_res("b3", -16'sd5,  16'd2,   4'd3, 2'b00);
    get_res("b4", -16'sd6,  16'd0,   4'd4, 2'b00);
    chk("b_rises", 16'(rises - r0), 16'd3);

    // Divide by zero
    r0 = rises;
    push(16'd7, 16'd0, 4'd5);
    get_res("z5", 16'd0, 16'd7, 4'd5, 2'b01);
    chk("z_rises", 16'(rises - r0), 16'd0);

    // Back-pressure: 1 in flight + 4 queued
    out_ready = 1'b0;
    push(16'd100,   16'd7,   4'd6);
    push(-16'sd100, 16'd7,   4'd7);
    push(16'd9,     16'd2,   4'd8);
    push(16'd50,    -16'sd6, 4'd9);
    push(16'd1,     16'd1,   4'd10);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge CLK); t++; end
    repeat (5) @(negedge CLK);
    chk("bp_in_ready", 16'(in_ready), 16'd0);
    chk("bp_hold_coc", out_coc, 16'd14);
    chk("bp_hold_tag", 16'(out_tag), 16'd6);
    out_ready = 1'b1;
    get_res("p6",  16'd14,   16'd2,   4'd6,  2'b00);
    get_res("p7",  -16'sd14, -16'sd2, 4'd7,  2'b00);
    get_res("p8",  16'd4,    16'd1,   4'd8,  2'b00);
    get_res("p9",  -16'sd8,  16'd2,   4'd9,  2'b00);
    get_res("p10", 16'd1,    16'd0,   4'd10, 2'b00);

    // Stuck divider -> timeout, then recovery
    dmodel_en = 1'b0;
    h0 = hi_cyc;
    push(16'd11, 16'd2, 4'd11);
    get_res("to11", 16'd0, 16'd0, 4'd11, 2'b10);
    chk("to_issue_cyc", 16'(hi_cyc - h0), 16'd64);
    dmodel_en = 1'b1;
    push(16'd15, 16'd3, 4'd12);
    get_res("r12", 16'd5, 16'd0, 4'd12, 2'b00);

    // Asynchronous reset while ISSUE
    push(16'd3, 16'd1, 4'd14);
    t = 0;
    while (!div_start && t < 20) begin @(negedge CLK); t++; end
    #2 RSTa = 1'b0;
    #1;
    chk("ar_div_start", 16'(div_start), 16'd0);
    chk("ar_out_valid", 16'(out_valid), 16'd0);
    chk("ar_in_ready",  16'(in_ready),  16'd1);
    @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    push(16'd20, -16'sd5, 4'd13);
    get_res("ar13", -16'sd4, 16'd0, 4'd13, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
